// File: rtl/instr_fetch.sv
// instr_fetch: fetch front end of the multicycle core.
// Owns the PC, fetches one word at a time and hands it to the decoder.
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    FETCH_START,
    REQ,
    HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] reset_pc;
  logic [ADDR_W-1:0] boff;
  logic [ADDR_W-1:0] jtgt;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;

  assign reset_pc  = {RESET_PC[ADDR_W-1:2], 2'b00};
  assign pc_plus4  = pc + ADDR_W'(4);
  assign imem_addr = pc;
  assign accept    = (state == HOLD) && instr_valid && instr_ready;

  assign boff = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign jtgt = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

  // jump outranks a taken branch when the decoder raises both
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jtgt;
    else if (branch && zero)
      next_pc = pc_plus4 + boff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= reset_pc;
      state       <= FETCH_START;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
    end else begin
      unique case (state)
        FETCH_START: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            pc          <= next_pc;
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state    <= FETCH_START;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random fetch/branch/jump sequences
// against a PC model computed with plain arithmetic.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int total = 0;
  int bad = 0;

  logic [31:0] mpc;
  logic [31:0] minst;

  instr_fetch #(
    .ADDR_W(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch(branch),
    .jump(jump),
    .zero(zero),
    .pc(pc),
    .pc_plus4(pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p,
      input logic [31:0] ins, input logic b, input logic j,
      input logic z);
    logic [31:0] p4;
    logic [15:0] imm;
    longint off;
    p4 = p + 32'd4;
    imm = ins[15:0];
    off = longint'($signed(imm)) * 4;
    if (j)
      return (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    if (b && z)
      return 32'(longint'(p4) + off);
    return p4;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    mpc = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] data, input int dly);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("req_addr", imem_addr, mpc);
    for (int i = 0; i < dly; i++) begin
      instr_ready = 1'($urandom);
      branch = 1'($urandom);
      jump = 1'($urandom);
      zero = 1'($urandom);
      tick();
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, mpc);
      chk("req_novalid", 32'(instr_valid), 32'd0);
    end
    instr_ready = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    minst = data;
    chk("rsp_valid", 32'(instr_valid), 32'd1);
    chk("rsp_instr", instr, data);
    chk("rsp_pc", pc, mpc);
    chk("rsp_pc4", pc_plus4, mpc + 32'd4);
    chk("rsp_req", 32'(imem_req), 32'd0);
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_ready = 1'($urandom);
      imem_rdata = 32'hDEAD_BEEF;
      instr_ready = 1'b0;
      branch = 1'($urandom);
      jump = 1'($urandom);
      zero = 1'($urandom);
      tick();
      chk("hold_instr", instr, minst);
      chk("hold_pc", pc, mpc);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic accept(input logic b, input logic j, input logic z);
    instr_ready = 1'b1;
    branch = b;
    jump = j;
    zero = z;
    mpc = ref_next(mpc, minst, b, j, z);
    tick();
    instr_ready = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
    chk("acc_valid", 32'(instr_valid), 32'd0);
    chk("acc_req", 32'(imem_req), 32'd1);
    chk("acc_addr", imem_addr, mpc);
  endtask

  initial begin
    reset = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
    mpc = 32'h0;
    minst = 32'h0;
    tick();

    // basic fetch at 0, then 4
    do_reset();
    tick();
    chk("fs_req", 32'(imem_req), 32'd1);
    chk("fs_addr", imem_addr, 32'h0);
    fetch(32'h2008_0005, 0);
    accept(1'b0, 1'b0, 1'b0);
    chk("seq_addr4", imem_addr, 32'h4);

    // jump to 0x40, negative taken branch to 0x3C
    fetch(32'h0800_0010, 0);
    accept(1'b0, 1'b1, 1'b0);
    chk("jmp_40", imem_addr, 32'h40);
    fetch(32'h1000_FFFE, 1);
    accept(1'b1, 1'b0, 1'b1);
    chk("br_taken", imem_addr, 32'h3C);

    // back to 0x40, untaken branch falls through
    fetch(32'h0800_0010, 0);
    accept(1'b0, 1'b1, 1'b0);
    fetch(32'h1000_FFFE, 2);
    accept(1'b1, 1'b0, 1'b0);
    chk("br_untaken", imem_addr, 32'h44);

    // long stall in HOLD with stray responses
    fetch(32'h1234_5678, 0);
    hold(5);
    accept(1'b0, 1'b0, 1'b0);
    chk("stall_next", imem_addr, 32'h48);

    // reach 0x1000_0000, then jump+branch together
    fetch(32'h0BFF_FFFF, 0);
    accept(1'b0, 1'b1, 1'b0);
    chk("jmp_top", imem_addr, 32'h0FFF_FFFC);
    fetch(32'h0000_0000, 0);
    accept(1'b0, 1'b0, 1'b0);
    chk("to_1000", imem_addr, 32'h1000_0000);
    fetch(32'h0800_0010, 0);
    accept(1'b1, 1'b1, 1'b1);
    chk("jmp_wins", imem_addr, 32'h1000_0040);

    // delayed response keeps request stable
    fetch(32'hCAFE_0001, 3);
    accept(1'b0, 1'b0, 1'b0);

    // reset mid-request discards responses
    tick();
    chk("r2_req", 32'(imem_req), 32'd1);
    chk("r2_addr", imem_addr, mpc);
    reset = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0BAD_C0DE;
    tick();
    reset = 1'b0;
    mpc = 32'h0;
    chk("rr_req", 32'(imem_req), 32'd0);
    chk("rr_valid", 32'(instr_valid), 32'd0);
    chk("rr_instr", instr, 32'h0);
    chk("rr_pc", pc, 32'h0);
    tick();
    imem_ready = 1'b0;
    chk("rr_restart", 32'(imem_req), 32'd1);
    chk("rr_addr", imem_addr, 32'h0);
    chk("rr_late", 32'(instr_valid), 32'd0);
    chk("rr_linstr", instr, 32'h0);

    // branch from 0 back to 0xFFFF_FFFC, then wrap
    fetch(32'h1000_FFFE, 0);
    accept(1'b1, 1'b0, 1'b1);
    chk("br_wrapneg", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 1);
    accept(1'b0, 1'b0, 1'b0);
    chk("wrap_zero", imem_addr, 32'h0);

    // reset while holding drops the instruction
    fetch(32'h5555_AAAA, 0);
    do_reset();

    // random traffic
    for (int k = 0; k < 60; k++) begin
      logic [31:0] w;
      w = $urandom;
      fetch(w, int'($urandom_range(0, 3)));
      hold(int'($urandom_range(0, 3)));
      accept(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
